accel_avg_bcd: RTL and testbench

- Sits directly downstream of the SPI accelerometer config/readback stage and consumes its X-axis byte pair {DATA_H, DATA_L}.
- Keeps a moving average over 2^AVG_LOG2 samples and converts the average to signed magnitude in 0.01 g units (256 LSB/g).
- Produces four BCD digits plus a sign flag for the hex_decoder/7-segment stage.
- BCD conversion is a sequential double-dabble engine, not a combinational divide chain.

---
 rtl/accel_avg_bcd.sv | 194 +++++++++++++++++++
 tb/tb_accel_avg_bcd.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/accel_avg_bcd.sv
// accel_avg_bcd: moving average of the X-axis accelerometer word, scaled to
// 0.01 g signed magnitude and converted to four BCD digits for the display.
// Optional peak-hold register and ports are enabled by ACCEL_PEAK_HOLD_EN.
module accel_avg_bcd #(
  parameter int AVG_LOG2 = 3,
  parameter int SAT_VAL  = 9999
) (
  input  logic        iSPI_CLK,
  input  logic        iRSTN,
  input  logic [7:0]  iDATA_L,
  input  logic [7:0]  iDATA_H,
  input  logic        iDATA_VLD,
`ifdef ACCEL_PEAK_HOLD_EN
  input  logic        iPEAK_CLR,
  output logic [13:0] oPEAK,
`endif
  output logic [15:0] oBCD,
  output logic        oNEG,
  output logic        oVALID,
  output logic        oBUSY
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [2:0] {IDLE, ABS, SCALE, CONV, DONE} state_e;

  state_e state_q, state_d;

  logic signed [15:0]   samp_q [DEPTH];
  logic signed [15:0]   samp_d [DEPTH];
  logic signed [SW-1:0] sum_q, sum_d;
  logic [PW-1:0]        wp_q, wp_d;
  logic                 pending_q, pending_d;
  logic                 neg_q, neg_d;
  logic [16:0]          mag_q, mag_d;
  logic [29:0]          conv_q, conv_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [15:0]          bcd_q, bcd_d;
  logic                 oneg_q, oneg_d;
  logic                 valid_q, valid_d;
`ifdef ACCEL_PEAK_HOLD_EN
  logic [13:0]          peak_q, peak_d;
`endif

  logic signed [15:0] new_word;
  logic signed [15:0] avg;
  logic signed [16:0] avg_x;
  logic [22:0]        mag_w;
  logic [22:0]        prod;
  logic [22:0]        centi_full;
  logic [13:0]        centi_sat;
  logic [15:0]        result;
  logic               start;

  // One double-dabble correction step: bump every digit of 5 or more by 3.
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign new_word   = {iDATA_H, iDATA_L};
  assign avg        = 16'(sum_q >>> AVG_LOG2);
  assign avg_x      = {avg[15], avg};
  assign mag_w      = 23'(mag_q);
  assign prod       = (mag_w << 6) + (mag_w << 5) + (mag_w << 2);
  assign centi_full = prod >> 8;
  assign centi_sat  = (centi_full > 23'(SAT_VAL)) ? 14'(SAT_VAL) : centi_full[13:0];
  assign result     = conv_q[29:14];
  assign start      = pending_q || iDATA_VLD;

  // State register; reset aborts any conversion in progress.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one pass through abs, scale, 14 shifts and a publish cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ABS;
      ABS:     state_d = SCALE;
      SCALE:   state_d = CONV;
      CONV:    if (cnt_q == 4'd13) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample absorption runs in every state; conversion datapath follows the FSM.
  always_comb begin
    samp_d    = samp_q;
    sum_d     = sum_q;
    wp_d      = wp_q;
    pending_d = pending_q;
    neg_d     = neg_q;
    mag_d     = mag_q;
    conv_d    = conv_q;
    cnt_d     = cnt_q;
    if (iDATA_VLD) begin
      sum_d         = sum_q + SW'(new_word) - SW'(samp_q[wp_q]);
      samp_d[wp_q]  = new_word;
      wp_d          = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      pending_d     = 1'b1;
    end
    unique case (state_q)
      IDLE:  if (start) pending_d = 1'b0;
      ABS: begin
        neg_d = avg[15];
        mag_d = avg[15] ? 17'(-avg_x) : 17'(avg_x);
      end
      SCALE: begin
        conv_d = {16'd0, centi_sat};
        cnt_d  = '0;
      end
      CONV: begin
        conv_d = {dabble_adj(conv_q[29:14]), conv_q[13:0]} << 1;
        cnt_d  = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Outputs change only on DONE; a zero magnitude never shows a minus sign.
  always_comb begin
    bcd_d   = bcd_q;
    oneg_d  = oneg_q;
    valid_d = 1'b0;
    if (state_q == DONE) begin
      bcd_d   = result;
      oneg_d  = neg_q && (result != 16'd0);
      valid_d = 1'b1;
    end
  end

`ifdef ACCEL_PEAK_HOLD_EN
  // Peak tracks the saturated centi value at SCALE; a clear overrides it.
  always_comb begin
    peak_d = peak_q;
    if ((state_q == SCALE) && (centi_sat > peak_q)) peak_d = centi_sat;
    if (iPEAK_CLR) peak_d = '0;
  end
`endif

  // Datapath and output registers.
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      for (int i = 0; i < DEPTH; i++) samp_q[i] <= '0;
      sum_q     <= '0;
      wp_q      <= '0;
      pending_q <= 1'b0;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      conv_q    <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      oneg_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef ACCEL_PEAK_HOLD_EN
      peak_q    <= '0;
`endif
    end else begin
      samp_q    <= samp_d;
      sum_q     <= sum_d;
      wp_q      <= wp_d;
      pending_q <= pending_d;
      neg_q     <= neg_d;
      mag_q     <= mag_d;
      conv_q    <= conv_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      oneg_q    <= oneg_d;
      valid_q   <= valid_d;
`ifdef ACCEL_PEAK_HOLD_EN
      peak_q    <= peak_d;
`endif
    end
  end

  assign oBCD   = bcd_q;
  assign oNEG   = oneg_q;
  assign oVALID = valid_q;
  assign oBUSY  = (state_q != IDLE) || pending_q;
`ifdef ACCEL_PEAK_HOLD_EN
  assign oPEAK  = peak_q;
`endif

endmodule

// File: tb/tb_accel_avg_bcd.sv
// tb_accel_avg_bcd: directed bench for accel_avg_bcd (depth 8) with a
// scoreboard of predicted display values popped on every oVALID pulse.
module tb_accel_avg_bcd;

  logic        iSPI_CLK = 1'b0;
  logic        iRSTN = 1'b1;
  logic [7:0]  iDATA_L = '0;
  logic [7:0]  iDATA_H = '0;
  logic        iDATA_VLD = 1'b0;
  logic [15:0] oBCD;
  logic        oNEG;
  logic        oVALID;
  logic        oBUSY;
`ifdef ACCEL_PEAK_HOLD_EN
  logic        iPEAK_CLR = 1'b0;
  logic [13:0] oPEAK;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int m_buf [8];
  int m_sum = 0;
  int m_wp = 0;
  int m_peak = 0;

  accel_avg_bcd #(.AVG_LOG2(3), .SAT_VAL(9999)) dut (
    .iSPI_CLK  (iSPI_CLK),
    .iRSTN     (iRSTN),
    .iDATA_L   (iDATA_L),
    .iDATA_H   (iDATA_H),
    .iDATA_VLD (iDATA_VLD),
`ifdef ACCEL_PEAK_HOLD_EN
    .iPEAK_CLR (iPEAK_CLR),
    .oPEAK     (oPEAK),
`endif
    .oBCD      (oBCD),
    .oNEG      (oNEG),
    .oVALID    (oVALID),
    .oBUSY     (oBUSY)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 iSPI_CLK = ~iSPI_CLK;

  always @(posedge iSPI_CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: floor average, magnitude, scale to 0.01 g, saturate, decimal digits.
  function automatic exp_t predict(input int at);
    int   avg;
    int   mag;
    int   c;
    exp_t e;
    avg = m_sum >>> 3;
    mag = (avg < 0) ? -avg : avg;
    c = (mag * 100) / 256;
    if (c > 9999) c = 9999;
    e.bcd = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    e.neg = (avg < 0) && (c != 0);
    e.at  = at;
    if (c > m_peak) m_peak = c;
    return e;
  endfunction

  // Called at a negedge: drives one sample for one cycle and updates the model.
  task automatic applyStimulus(input logic [15:0] w, input bit push, input int at);
    logic signed [15:0] ws;
    ws = w;
    {iDATA_H, iDATA_L} = w;
    iDATA_VLD = 1'b1;
    m_sum = m_sum + int'(ws) - m_buf[m_wp];
    m_buf[m_wp] = int'(ws);
    m_wp = (m_wp + 1) % 8;
    if (push) sb.push_back(predict(at));
    @(negedge iSPI_CLK);
    iDATA_VLD = 1'b0;
  endtask

  task automatic spaced(input logic [15:0] w);
    applyStimulus(w, 1'b1, cyc + 18);
    repeat (29) @(negedge iSPI_CLK);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge iSPI_CLK);
      n++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  // Scoreboard monitor: every oVALID pulse must match the oldest prediction.
  always @(negedge iSPI_CLK) begin
    if (iRSTN && oVALID) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("[TB] FAIL unexpected_valid: observed bcd %0h with empty scoreboard", oBCD);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput("bcd", oBCD, mon_e.bcd);
        checkOutput("neg", oNEG, mon_e.neg);
        if (mon_e.at >= 0) checkOutput("latency", cyc, mon_e.at);
      end
    end
  end

  initial begin
    int t0;
    for (int i = 0; i < 8; i++) m_buf[i] = 0;

    // Reset and idle behaviour
    #1 iRSTN = 1'b0;
    repeat (3) @(negedge iSPI_CLK);
    checkOutput("rst_bcd", oBCD, 16'h0000);
    checkOutput("rst_neg", oNEG, 1'b0);
    checkOutput("rst_valid", oVALID, 1'b0);
    checkOutput("rst_busy", oBUSY, 1'b0);
    iRSTN = 1'b1;
    repeat (40) @(negedge iSPI_CLK);
    checkOutput("idle_busy", oBUSY, 1'b0);
    checkOutput("idle_bcd", oBCD, 16'h0000);

    // Ramp-up from an empty buffer, then one zero sample
    for (int k = 0; k < 8; k++) spaced(16'h0200);
    checkOutput("ramp_full", oBCD, 16'h0200);
    spaced(16'h0000);
    checkOutput("ramp_drop", oBCD, 16'h0175);

    // Negative values and negative-zero suppression
    for (int k = 0; k < 8; k++) spaced(16'hFF80);
    checkOutput("neg_bcd", oBCD, 16'h0050);
    checkOutput("neg_flag", oNEG, 1'b1);
    for (int k = 0; k < 8; k++) spaced(16'hFFFF);
    checkOutput("negzero_bcd", oBCD, 16'h0000);
    checkOutput("negzero_flag", oNEG, 1'b0);

    // Full-scale saturation in both directions
    for (int k = 0; k < 8; k++) spaced(16'h7FFF);
    checkOutput("satpos_bcd", oBCD, 16'h9999);
    checkOutput("satpos_neg", oNEG, 1'b0);
    for (int k = 0; k < 8; k++) spaced(16'h8000);
    checkOutput("satneg_bcd", oBCD, 16'h9999);
    checkOutput("satneg_neg", oNEG, 1'b1);

    // Three samples inside one conversion give exactly one extra conversion
    t0 = cyc;
    applyStimulus(16'h0100, 1'b1, t0 + 18);
    checkOutput("burst_busy", oBUSY, 1'b1);
    repeat (3) @(negedge iSPI_CLK);
    applyStimulus(16'h0200, 1'b0, -1);
    repeat (2) @(negedge iSPI_CLK);
    applyStimulus(16'h0300, 1'b1, t0 + 36);
    drain(100);
    repeat (40) @(negedge iSPI_CLK);
    checkOutput("burst_idle", oBUSY, 1'b0);

`ifdef ACCEL_PEAK_HOLD_EN
    checkOutput("peak_max", oPEAK, 14'(m_peak));
    iPEAK_CLR = 1'b1;
    @(negedge iSPI_CLK);
    iPEAK_CLR = 1'b0;
    checkOutput("peak_clr", oPEAK, 14'd0);
    m_peak = 0;
`endif

    // Reset in mid-conversion clears everything and suppresses oVALID
    applyStimulus(16'h0100, 1'b0, -1);
    repeat (5) @(negedge iSPI_CLK);
    iRSTN = 1'b0;
    #1;
    checkOutput("abort_bcd", oBCD, 16'h0000);
    checkOutput("abort_neg", oNEG, 1'b0);
    checkOutput("abort_busy", oBUSY, 1'b0);
    for (int i = 0; i < 8; i++) m_buf[i] = 0;
    m_sum = 0;
    m_wp = 0;
    m_peak = 0;
    @(negedge iSPI_CLK);
    iRSTN = 1'b1;
    repeat (30) @(negedge iSPI_CLK);
    spaced(16'h0100);
    checkOutput("post_rst_bcd", oBCD, 16'h0012);
`ifdef ACCEL_PEAK_HOLD_EN
    checkOutput("peak_after_rst", oPEAK, 14'(m_peak));
`endif

    drain(100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
